// File: rtl/input_debounce_if.sv
// Pin-conditioning bundle: raw pins in, clean levels and edge pulses out.
// The debouncer takes the slave side; the pin source and the consumers take the master side.
interface input_debounce_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] pin_in;
    logic [NCH-1:0] level_out;
    logic [NCH-1:0] rise_pulse;
    logic [NCH-1:0] fall_pulse;
    logic [NCH-1:0] toggle_out;

    modport master (
        output pin_in,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  toggle_out
    );

    modport slave (
        input  pin_in,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output toggle_out
    );
endinterface

// File: rtl/input_debounce.sv
// Purpose: 2-flop sync + per-channel stability-counter debounce with registered rise/fall pulses (toggle state under DEBOUNCE_TOGGLE_EN).
// Latency: a clean pin step reaches level_out DEBOUNCE_CYCLES+2 clk cycles later; pulses coincide with the new level.
// Backpressure: none, free-running every cycle; channels are independent.
module input_debounce #(
    parameter int NCH             = 4,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int CNT_W           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input_debounce_if.slave io
);

    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cfg
        $error("input_debounce: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   s1_q;
    logic [NCH-1:0]   s2_q;
    logic [NCH-1:0]   level_q;
    logic [NCH-1:0]   level_nxt;
    logic [NCH-1:0]   rise_q;
    logic [NCH-1:0]   fall_q;
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];

    // The counter is the per-channel state: zero means stable, non-zero means a
    // mismatch run is being qualified. Any matching cycle drops it back to zero.
    always_comb begin
        level_nxt = level_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            if (s2_q[i] == level_q[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_nxt[i] = s2_q[i];
                cnt_nxt[i]   = '0;
            end else begin
                cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= io.pin_in;
            s2_q    <= s1_q;
            level_q <= level_nxt;
            rise_q  <= level_nxt & ~level_q;
            fall_q  <= ~level_nxt & level_q;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
        end
    end

    assign io.level_out  = level_q;
    assign io.rise_pulse = rise_q;
    assign io.fall_pulse = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
    logic [NCH-1:0] toggle_q;

    // Flips the cycle after each rise pulse: push-on/push-off control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_q ^ rise_q;
        end
    end

    assign io.toggle_out = toggle_q;
`else
    assign io.toggle_out = '0;
`endif

endmodule
